// File: rtl/ysyx_24100005_rf_wb_arbiter_pkg.sv
// Shared constants and types for the register-file write-back arbiter
// and its busy scoreboard.
package ysyx_24100005_rf_wb_arbiter_pkg;

    localparam int SRC_EXU   = 0;
    localparam int SRC_LSU   = 1;
    localparam int NR_WB_SRC = 2;
    localparam int NR_REGS   = 32;

    typedef enum logic {
        WB_EXU = 1'b0,
        WB_LSU = 1'b1
    } wb_src_e;

    // Mux key: the top bit marks a live transfer, so an idle port selects no entry.
    function automatic logic [1:0] wb_key(input logic fire, input wb_src_e src);
        return {fire, src};
    endfunction

endpackage

// File: rtl/ysyx_24100005_rf_wb_arbiter_if.sv
// Write-back, issue and busy-query signals between the EXU/LSU/IDU
// and the register-file write-back arbiter.
interface ysyx_24100005_rf_wb_arbiter_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  exu_valid;
    logic                  exu_ready;
    logic [ADDR_WIDTH-1:0] exu_waddr;
    logic [DATA_WIDTH-1:0] exu_wdata;

    logic                  lsu_valid;
    logic                  lsu_ready;
    logic [ADDR_WIDTH-1:0] lsu_waddr;
    logic [DATA_WIDTH-1:0] lsu_wdata;

    logic                  iss_valid;
    logic                  iss_ready;
    logic [ADDR_WIDTH-1:0] iss_rd;

    logic [ADDR_WIDTH-1:0] rs1addr;
    logic [ADDR_WIDTH-1:0] rs2addr;
    logic                  rs1_busy;
    logic                  rs2_busy;

    logic                  rf_wen;
    logic [ADDR_WIDTH-1:0] rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;

    modport master (
        output exu_valid, exu_waddr, exu_wdata,
        output lsu_valid, lsu_waddr, lsu_wdata,
        output iss_valid, iss_rd, rs1addr, rs2addr,
        input  exu_ready, lsu_ready, iss_ready, rs1_busy, rs2_busy,
        input  rf_wen, rf_waddr, rf_wdata
    );

    modport slave (
        input  exu_valid, exu_waddr, exu_wdata,
        input  lsu_valid, lsu_waddr, lsu_wdata,
        input  iss_valid, iss_rd, rs1addr, rs2addr,
        output exu_ready, lsu_ready, iss_ready, rs1_busy, rs2_busy,
        output rf_wen, rf_waddr, rf_wdata
    );

endinterface

// File: rtl/ysyx_24100005_rf_scoreboard.sv
// Per-register busy bitmap: set on issue, cleared on write-back, with two
// query ports for decode and the issue stall for the destination register.
module ysyx_24100005_rf_scoreboard
    import ysyx_24100005_rf_wb_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    output logic                  iss_ready,
    input  logic                  wb_fire,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [ADDR_WIDTH-1:0] rs1addr,
    input  logic [ADDR_WIDTH-1:0] rs2addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy
);

    logic [NR_REGS-1:0] busy;
    logic [NR_REGS-1:0] busy_nxt;
    logic               iss_fire;

    assign iss_ready = !rst && (iss_rd == '0 || !busy[iss_rd]);
    assign iss_fire  = iss_valid && iss_ready;

    // Set is applied after clear so a same-register collision leaves the bit set.
    always_comb begin
        busy_nxt = busy;
        if (wb_fire) begin
            busy_nxt[wb_addr] = 1'b0;
        end
        if (iss_fire) begin
            busy_nxt[iss_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign rs1_busy = !rst && busy[rs1addr];
    assign rs2_busy = !rst && busy[rs2addr];

    always_ff @(posedge clk) begin
        if (!rst && wb_fire && wb_addr != '0) begin
            wb_to_idle_reg: assert (busy[wb_addr])
                else $error("write-back to non-busy register x%0d", wb_addr);
        end
    end

endmodule

// File: rtl/ysyx_24100005_rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between EXU and
// LSU write-back, plus the busy scoreboard that gates issue.
module ysyx_24100005_rf_wb_arbiter
    import ysyx_24100005_rf_wb_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    ysyx_24100005_rf_wb_arbiter_if.slave    bus
);

    logic                  exu_req;
    logic                  lsu_req;
    logic                  grant_exu;
    logic                  grant_lsu;
    logic                  wb_fire;
    wb_src_e               wb_src;
    wb_src_e               last_grant;
    logic [0:0]            last_grant_q;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic [DATA_WIDTH-1:0] wb_data;

    assign exu_req = bus.exu_valid && !rst;
    assign lsu_req = bus.lsu_valid && !rst;

    // Under contention the source that did not win last time goes first.
    always_comb begin
        grant_exu = 1'b0;
        grant_lsu = 1'b0;
        if (exu_req && lsu_req) begin
            if (last_grant == WB_LSU) begin
                grant_exu = 1'b1;
            end else begin
                grant_lsu = 1'b1;
            end
        end else begin
            grant_exu = exu_req;
            grant_lsu = lsu_req;
        end
    end

    assign wb_fire       = grant_exu || grant_lsu;
    assign wb_src        = grant_lsu ? WB_LSU : WB_EXU;
    assign bus.exu_ready = grant_exu;
    assign bus.lsu_ready = grant_lsu;

    ysyx_24100005_reg #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_last_grant (
        .clk  (clk),
        .rst  (rst),
        .din  (wb_src),
        .dout (last_grant_q),
        .wen  (wb_fire)
    );
    assign last_grant = wb_src_e'(last_grant_q);

    ysyx_24100005_mux_key #(
        .NR_KEY   (NR_WB_SRC),
        .KEY_LEN  (2),
        .DATA_LEN (ADDR_WIDTH)
    ) u_addr_mux (
        .out (wb_addr),
        .key (wb_key(wb_fire, wb_src)),
        .lut ({wb_key(1'b1, WB_LSU), bus.lsu_waddr,
               wb_key(1'b1, WB_EXU), bus.exu_waddr})
    );

    ysyx_24100005_mux_key #(
        .NR_KEY   (NR_WB_SRC),
        .KEY_LEN  (2),
        .DATA_LEN (DATA_WIDTH)
    ) u_data_mux (
        .out (wb_data),
        .key (wb_key(wb_fire, wb_src)),
        .lut ({wb_key(1'b1, WB_LSU), bus.lsu_wdata,
               wb_key(1'b1, WB_EXU), bus.exu_wdata})
    );

    // x0 writes still complete the handshake but never reach the port.
    assign bus.rf_wen   = wb_fire && wb_addr != '0;
    assign bus.rf_waddr = wb_addr;
    assign bus.rf_wdata = wb_data;

    ysyx_24100005_rf_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (bus.iss_valid),
        .iss_rd    (bus.iss_rd),
        .iss_ready (bus.iss_ready),
        .wb_fire   (wb_fire),
        .wb_addr   (wb_addr),
        .rs1addr   (bus.rs1addr),
        .rs2addr   (bus.rs2addr),
        .rs1_busy  (bus.rs1_busy),
        .rs2_busy  (bus.rs2_busy)
    );

endmodule

// Register with write enable and synchronous reset to RESET_VAL.
module ysyx_24100005_reg #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    input  logic             wen
);

    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= RESET_VAL;
        end else if (wen) begin
            dout <= din;
        end
    end

endmodule

// Keyed mux: lut packs {key, data} pairs; an unmatched key yields zero.
module ysyx_24100005_mux_key #(
    parameter int NR_KEY   = 2,
    parameter int KEY_LEN  = 1,
    parameter int DATA_LEN = 1
) (
    output logic [DATA_LEN-1:0]                  out,
    input  logic [KEY_LEN-1:0]                   key,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut
);

    localparam int PAIR_LEN = KEY_LEN + DATA_LEN;

    always_comb begin
        out = '0;
        for (int i = 0; i < NR_KEY; i++) begin
            if (lut[i*PAIR_LEN+DATA_LEN +: KEY_LEN] == key) begin
                out = lut[i*PAIR_LEN +: DATA_LEN];
            end
        end
    end

endmodule

// File: tb/tb_ysyx_24100005_rf_wb_arbiter.sv
// Self-checking bench for the write-back arbiter: directed scenarios plus a
// randomized run checked against a behavioural grant/scoreboard model.
`timescale 1ns/10ps
module tb_ysyx_24100005_rf_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ysyx_24100005_rf_wb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    ysyx_24100005_rf_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: busy set, last winner (0=EXU, 1=LSU), expected regfile.
    logic [31:0]   busy_m;
    int            last_m;
    logic [DW-1:0] exp_rf [32] = '{default: '0};
    logic [DW-1:0] dut_rf [32] = '{default: '0};

    function automatic int wb_src(input logic ev, input logic lv, input int last);
        if (ev && lv) return (last == 0) ? 1 : 0;
        if (ev) return 0;
        if (lv) return 1;
        return -1;
    endfunction

    function automatic logic [31:0] next_busy(input logic [31:0] b, input int src,
                                              input int ea, input int la,
                                              input logic iv, input int rd);
        logic [31:0] nb;
        nb = b;
        if (src == 0) nb[ea] = 1'b0;
        if (src == 1) nb[la] = 1'b0;
        if (iv && !b[rd]) nb[rd] = 1'b1;
        nb[0] = 1'b0;
        return nb;
    endfunction

    int cur_src;
    assign cur_src = wb_src(bus.exu_valid, bus.lsu_valid, last_m);

    always @(posedge clk) begin
        if (rst) begin
            busy_m <= '0;
            last_m <= 1;
        end else begin
            busy_m <= next_busy(busy_m, cur_src, int'(bus.exu_waddr), int'(bus.lsu_waddr),
                                bus.iss_valid, int'(bus.iss_rd));
            if (cur_src >= 0) last_m <= cur_src;
            if (cur_src == 0 && bus.exu_waddr != 0) exp_rf[bus.exu_waddr] <= bus.exu_wdata;
            if (cur_src == 1 && bus.lsu_waddr != 0) exp_rf[bus.lsu_waddr] <= bus.lsu_wdata;
        end
    end

    // Register file sink fed by the DUT write port.
    always @(posedge clk) begin
        if (bus.rf_wen) dut_rf[bus.rf_waddr] <= bus.rf_wdata;
    end

    task automatic idle_inputs();
        bus.exu_valid = 1'b0; bus.exu_waddr = '0; bus.exu_wdata = '0;
        bus.lsu_valid = 1'b0; bus.lsu_waddr = '0; bus.lsu_wdata = '0;
        bus.iss_valid = 1'b0; bus.iss_rd = '0;
        bus.rs1addr = '0; bus.rs2addr = '0;
    endtask

    task automatic issue(input logic [4:0] rd);
        @(negedge clk);
        idle_inputs();
        bus.iss_valid = 1'b1;
        bus.iss_rd = rd;
        #1;
        checks++;
        if (bus.iss_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready x%0d: got %b expected 1", rd, bus.iss_ready);
        end
    endtask

    task automatic test_reset();
        logic [42:0] obs;
        rst = 1'b1;
        idle_inputs();
        bus.exu_valid = 1'b1; bus.exu_waddr = 5'd3; bus.exu_wdata = 32'h1234_5678;
        bus.lsu_valid = 1'b1; bus.lsu_waddr = 5'd4; bus.lsu_wdata = 32'h8765_4321;
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd6;
        bus.rs1addr = 5'd3; bus.rs2addr = 5'd6;
        repeat (3) begin
            @(negedge clk);
            #1;
            obs = {bus.exu_ready, bus.lsu_ready, bus.iss_ready, bus.rf_wen,
                   bus.rf_waddr, bus.rf_wdata, bus.rs1_busy, bus.rs2_busy};
            checks++;
            if (obs !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got %h expected 0", obs);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        #1;
        for (int i = 0; i < 32; i++) begin
            bus.rs1addr = 5'(i);
            bus.rs2addr = 5'(31 - i);
            bus.iss_rd = 5'(i);
            #0.1;
            checks++;
            if ({bus.rs1_busy, bus.rs2_busy, bus.iss_ready} !== 3'b001) begin
                errors++;
                $display("FAIL reset_busy x%0d: got %b expected 001", i,
                         {bus.rs1_busy, bus.rs2_busy, bus.iss_ready});
            end
        end
    endtask

    task automatic test_single_writer();
        issue(5'd5);
        @(negedge clk);
        idle_inputs();
        bus.rs1addr = 5'd5;
        bus.exu_valid = 1'b1; bus.exu_waddr = 5'd5; bus.exu_wdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (bus.rs1_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_busy_set: got %b expected 1", bus.rs1_busy);
        end
        checks++;
        if ({bus.exu_ready, bus.lsu_ready} !== 2'b10) begin
            errors++;
            $display("FAIL single_ready: got %b expected 10", {bus.exu_ready, bus.lsu_ready});
        end
        checks++;
        if ({bus.rf_wen, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL single_port: got %b/%0d/%h expected 1/5/deadbeef",
                     bus.rf_wen, bus.rf_waddr, bus.rf_wdata);
        end
        @(negedge clk);
        idle_inputs();
        bus.rs1addr = 5'd5;
        #1;
        checks++;
        if (dut_rf[5] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL single_rf_x5: got %h expected deadbeef", dut_rf[5]);
        end
        checks++;
        if (bus.rs1_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_busy_clr: got %b expected 0", bus.rs1_busy);
        end
    endtask

    task automatic test_x0_write();
        @(negedge clk);
        idle_inputs();
        bus.lsu_valid = 1'b1; bus.lsu_waddr = 5'd0; bus.lsu_wdata = 32'hCAFE_F00D;
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
        #1;
        checks++;
        if ({bus.lsu_ready, bus.rf_wen, bus.iss_ready} !== 3'b101) begin
            errors++;
            $display("FAIL x0_handshake: got %b expected 101",
                     {bus.lsu_ready, bus.rf_wen, bus.iss_ready});
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (bus.rs1_busy !== 1'b0) begin
            errors++;
            $display("FAIL x0_busy: got %b expected 0", bus.rs1_busy);
        end
        checks++;
        if (dut_rf[0] !== '0) begin
            errors++;
            $display("FAIL x0_value: got %h expected 0", dut_rf[0]);
        end
    endtask

    task automatic test_contention();
        int ei, li, exp_g;
        logic [4:0] ea [3];
        logic [4:0] la [3];
        logic [4:0] wa;
        ea = '{5'd10, 5'd12, 5'd14};
        la = '{5'd11, 5'd13, 5'd15};
        for (int r = 10; r < 16; r++) issue(5'(r));
        ei = 0;
        li = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            idle_inputs();
            bus.exu_valid = (ei < 3);
            bus.exu_waddr = ea[(ei < 3) ? ei : 2];
            bus.exu_wdata = 32'h1000_0000 + 32'(bus.exu_waddr);
            bus.lsu_valid = (li < 3);
            bus.lsu_waddr = la[(li < 3) ? li : 2];
            bus.lsu_wdata = 32'h1000_0000 + 32'(bus.lsu_waddr);
            #1;
            exp_g = c % 2;
            wa = (exp_g == 0) ? ea[ei] : la[li];
            checks++;
            if ({bus.exu_ready, bus.lsu_ready} !== ((exp_g == 0) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL contention_grant c%0d: got %b expected %s", c,
                         {bus.exu_ready, bus.lsu_ready}, (exp_g == 0) ? "EXU" : "LSU");
            end
            checks++;
            if ({bus.rf_wen, bus.rf_waddr, bus.rf_wdata} !== {1'b1, wa, 32'h1000_0000 + 32'(wa)}) begin
                errors++;
                $display("FAIL contention_port c%0d: got %b/%0d/%h expected 1/%0d", c,
                         bus.rf_wen, bus.rf_waddr, bus.rf_wdata, wa);
            end
            if (exp_g == 0) ei++; else li++;
        end
        @(negedge clk);
        idle_inputs();
        #1;
        for (int r = 10; r < 16; r++) begin
            checks++;
            if (dut_rf[r] !== 32'h1000_0000 + 32'(r)) begin
                errors++;
                $display("FAIL contention_rf x%0d: got %h expected %h", r, dut_rf[r],
                         32'h1000_0000 + 32'(r));
            end
        end
    endtask

    task automatic test_scoreboard();
        issue(5'd7);
        @(negedge clk);
        idle_inputs();
        bus.iss_rd = 5'd7; bus.rs1addr = 5'd7; bus.rs2addr = 5'd7;
        #1;
        checks++;
        if ({bus.rs1_busy, bus.rs2_busy, bus.iss_ready} !== 3'b110) begin
            errors++;
            $display("FAIL sb_set: got %b expected 110", {bus.rs1_busy, bus.rs2_busy, bus.iss_ready});
        end
        @(negedge clk);
        bus.iss_valid = 1'b1;
        bus.lsu_valid = 1'b1; bus.lsu_waddr = 5'd7; bus.lsu_wdata = 32'h0000_0077;
        #1;
        checks++;
        if ({bus.iss_ready, bus.lsu_ready, bus.rs1_busy} !== 3'b011) begin
            errors++;
            $display("FAIL sb_stall_wb: got %b expected 011", {bus.iss_ready, bus.lsu_ready, bus.rs1_busy});
        end
        @(negedge clk);
        bus.iss_valid = 1'b0;
        bus.lsu_valid = 1'b0;
        #1;
        checks++;
        if ({bus.rs1_busy, bus.iss_ready} !== 2'b01) begin
            errors++;
            $display("FAIL sb_clear: got %b expected 01", {bus.rs1_busy, bus.iss_ready});
        end
        checks++;
        if (dut_rf[7] !== 32'h0000_0077) begin
            errors++;
            $display("FAIL sb_rf_x7: got %h expected 77", dut_rf[7]);
        end
    endtask

    task automatic test_reset_midflight();
        issue(5'd3);
        issue(5'd9);
        issue(5'd4);
        @(negedge clk);
        idle_inputs();
        bus.exu_valid = 1'b1; bus.exu_waddr = 5'd4; bus.exu_wdata = 32'h4444_4444;
        bus.rs1addr = 5'd3; bus.rs2addr = 5'd9;
        #1;
        checks++;
        if ({bus.rs1_busy, bus.rs2_busy, bus.exu_ready} !== 3'b111) begin
            errors++;
            $display("FAIL mid_pre: got %b expected 111", {bus.rs1_busy, bus.rs2_busy, bus.exu_ready});
        end
        @(negedge clk);
        rst = 1'b1;
        bus.exu_valid = 1'b1; bus.exu_waddr = 5'd3; bus.exu_wdata = 32'h3333_3333;
        bus.lsu_valid = 1'b1; bus.lsu_waddr = 5'd9; bus.lsu_wdata = 32'h9999_9999;
        #1;
        checks++;
        if ({bus.exu_ready, bus.lsu_ready, bus.rf_wen} !== 3'b000) begin
            errors++;
            $display("FAIL mid_rst_ready: got %b expected 000", {bus.exu_ready, bus.lsu_ready, bus.rf_wen});
        end
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        bus.rs1addr = 5'd3; bus.rs2addr = 5'd9; bus.iss_rd = 5'd3;
        #1;
        checks++;
        if ({bus.rs1_busy, bus.rs2_busy, bus.iss_ready} !== 3'b001) begin
            errors++;
            $display("FAIL mid_cleared: got %b expected 001", {bus.rs1_busy, bus.rs2_busy, bus.iss_ready});
        end
        issue(5'd20);
        issue(5'd21);
        @(negedge clk);
        idle_inputs();
        bus.exu_valid = 1'b1; bus.exu_waddr = 5'd20; bus.exu_wdata = 32'h2020_2020;
        bus.lsu_valid = 1'b1; bus.lsu_waddr = 5'd21; bus.lsu_wdata = 32'h2121_2121;
        #1;
        checks++;
        if ({bus.exu_ready, bus.lsu_ready} !== 2'b10) begin
            errors++;
            $display("FAIL mid_first_contest: got %b expected 10", {bus.exu_ready, bus.lsu_ready});
        end
        @(negedge clk);
        bus.exu_valid = 1'b0;
        #1;
        checks++;
        if ({bus.exu_ready, bus.lsu_ready} !== 2'b01) begin
            errors++;
            $display("FAIL mid_lsu_drain: got %b expected 01", {bus.exu_ready, bus.lsu_ready});
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_random();
        int pool [$];
        int idx, src;
        logic e_hold, l_hold, iss_fire;
        logic [4:0] wa;
        logic [DW-1:0] wd;
        logic [42:0] exp_v, obs;
        e_hold = 1'b0;
        l_hold = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!e_hold && $urandom_range(0, 2) != 0) begin
                if (pool.size() > 0 && $urandom_range(0, 7) != 0) begin
                    idx = $urandom_range(0, pool.size() - 1);
                    bus.exu_waddr = 5'(pool[idx]);
                    pool.delete(idx);
                end else begin
                    bus.exu_waddr = '0;
                end
                bus.exu_wdata = $urandom;
                e_hold = 1'b1;
            end
            if (!l_hold && $urandom_range(0, 2) != 0) begin
                if (pool.size() > 0 && $urandom_range(0, 7) != 0) begin
                    idx = $urandom_range(0, pool.size() - 1);
                    bus.lsu_waddr = 5'(pool[idx]);
                    pool.delete(idx);
                end else begin
                    bus.lsu_waddr = '0;
                end
                bus.lsu_wdata = $urandom;
                l_hold = 1'b1;
            end
            bus.exu_valid = e_hold;
            bus.lsu_valid = l_hold;
            bus.iss_valid = 1'($urandom_range(0, 1));
            bus.iss_rd = 5'($urandom_range(0, 31));
            bus.rs1addr = 5'($urandom_range(0, 31));
            bus.rs2addr = 5'($urandom_range(0, 31));
            #1;
            src = wb_src(e_hold, l_hold, last_m);
            wa = (src == 0) ? bus.exu_waddr : (src == 1) ? bus.lsu_waddr : 5'd0;
            wd = (src == 0) ? bus.exu_wdata : (src == 1) ? bus.lsu_wdata : '0;
            exp_v = {src == 0, src == 1, busy_m[bus.iss_rd] == 1'b0, src >= 0 && wa != 0,
                     wa, wd, busy_m[bus.rs1addr], busy_m[bus.rs2addr]};
            obs = {bus.exu_ready, bus.lsu_ready, bus.iss_ready, bus.rf_wen,
                   bus.rf_waddr, bus.rf_wdata, bus.rs1_busy, bus.rs2_busy};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL random_cycle %0d: got %h expected %h", c, obs, exp_v);
            end
            iss_fire = bus.iss_valid && !busy_m[bus.iss_rd];
            if (src == 0) e_hold = 1'b0;
            if (src == 1) l_hold = 1'b0;
            if (iss_fire && bus.iss_rd != 0) pool.push_back(int'(bus.iss_rd));
        end
        @(negedge clk);
        idle_inputs();
        #1;
        for (int r = 0; r < 32; r++) begin
            checks++;
            if (dut_rf[r] !== exp_rf[r]) begin
                errors++;
                $display("FAIL random_rf x%0d: got %h expected %h", r, dut_rf[r], exp_rf[r]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        test_reset();
        test_single_writer();
        test_x0_write();
        test_contention();
        test_scoreboard();
        test_reset_midflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
